// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shift unit: widths, op encodings,
// FSM states and the remaining-amount priority select.
package shifter_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int STEP_W  = 3;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Index of the highest set bit; larger steps are taken first.
  function automatic logic [STEP_W-1:0] msb_index(input logic [SHAMT_W-1:0] v);
    msb_index = '0;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (v[i]) msb_index = STEP_W'(i);
    end
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One power-of-two shift step (1 << k_i positions) for sll, srl, sra and rol.
module shift_stage
  import shifter_pkg::*;
(
  input  logic [WIDTH-1:0]  val_i,
  input  logic [STEP_W-1:0] k_i,
  input  op_e               op_i,
  output logic [WIDTH-1:0]  val_o
);

  logic [SHAMT_W-1:0]   step;
  logic [2*WIDTH-1:0]   rot_wide;

  assign step     = SHAMT_W'(1) << k_i;
  // Upper half of the doubled word shifted left is the rotated value.
  assign rot_wide = {val_i, val_i} << step;

  always_comb begin
    val_o = val_i;
    unique case (op_i)
      OP_SLL: val_o = val_i << step;
      OP_SRL: val_o = val_i >> step;
      OP_SRA: val_o = $unsigned($signed(val_i) >>> step);
      OP_ROL: val_o = rot_wide[2*WIDTH-1:WIDTH];
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: one power-of-two step per cycle, largest step first,
// ending with a single-cycle result_valid pulse and a held result.
module iterative_shifter
  import shifter_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic               ready,
  output logic               busy,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               valid_q, valid_d;

  logic [STEP_W-1:0]  k;
  logic [WIDTH-1:0]   stage_val;
  logic [SHAMT_W-1:0] rem_next;

  assign k        = msb_index(rem_q);
  assign rem_next = rem_q & ~(SHAMT_W'(1) << k);

  shift_stage u_stage (
    .val_i (acc_q),
    .k_i   (k),
    .op_i  (op_q),
    .val_o (stage_val)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_d = data_in;
          rem_d = shamt;
          op_d  = op_e'(op);
          if (shamt == '0) begin
            state_d  = DONE;
            result_d = data_in;
            valid_d  = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = stage_val;
        rem_d = rem_next;
        // Result is captured on the same edge that enters DONE.
        if (rem_next == '0) begin
          state_d  = DONE;
          result_d = stage_val;
          valid_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      op_q     <= OP_SLL;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign ready        = (state_q != SHIFT);
  assign busy         = (state_q == SHIFT);
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter against a whole-shift reference model.
module tb_iterative_shifter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        ready;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;

  int n_cmp = 0;
  int n_err = 0;

  iterative_shifter dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .data_in      (data_in),
    .shamt        (shamt),
    .op           (op),
    .ready        (ready),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Full shift in one go, straight from the op definitions.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh,
                                            input logic [1:0] o);
    case (o)
      2'd0:    return d << sh;
      2'd1:    return d >> sh;
      2'd2:    return 32'($signed(d) >>> sh);
      default: return (sh == 0) ? d : ((d << sh) | (d >> (32 - sh)));
    endcase
  endfunction

  task automatic launch(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] o);
    @(negedge clock);
    start = 1'b1; data_in = d; shamt = sh; op = o;
    @(posedge clock); #1;
    start = 1'b0; data_in = $urandom; shamt = 5'($urandom); op = 2'($urandom);
  endtask

  // Counts edges after the accept edge until result_valid, and busy samples seen meanwhile.
  task automatic wait_valid(output int lat, output int busy_cnt, output bit timeout);
    lat = 0; busy_cnt = 0;
    while (!result_valid && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clock); #1;
      lat++;
    end
    timeout = !result_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; data_in = '0; shamt = '0; op = '0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] d_t [5] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 32'hDEAD_BEEF};
    logic [4:0]  s_t [5] = '{5'd31, 5'd4, 5'd4, 5'd1, 5'd0};
    logic [1:0]  o_t [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
    logic [31:0] e_t [5] = '{32'h8000_0000, 32'hF800_0000, 32'h0800_0000, 32'h0000_0003, 32'hDEAD_BEEF};
    int          l_t [5] = '{5, 1, 1, 1, 0};
    int lat, bc; bit to;
    for (int i = 0; i < 5; i++) begin
      launch(d_t[i], s_t[i], o_t[i]);
      wait_valid(lat, bc, to);
      n_cmp++; if (to) begin n_err++; $display("FAIL dir%0d_timeout no result_valid", i); end
      n_cmp++; if (lat != l_t[i]) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, l_t[i]); end
      n_cmp++; if (bc != l_t[i]) begin n_err++; $display("FAIL dir%0d_busy got=%0d exp=%0d", i, bc, l_t[i]); end
      n_cmp++; if (result !== e_t[i]) begin n_err++; $display("FAIL dir%0d_result got=%h exp=%h", i, result, e_t[i]); end
      @(posedge clock); #1;
      n_cmp++; if (result_valid !== 1'b0 || result !== e_t[i] || ready !== 1'b1) begin
        n_err++; $display("FAIL dir%0d_hold valid=%b result=%h ready=%b exp valid=0 result=%h ready=1",
                          i, result_valid, result, ready, e_t[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, exp; logic [4:0] sh; logic [1:0] o;
    int lat, bc; bit to;
    for (int i = 0; i < 40; i++) begin
      d = $urandom; sh = 5'($urandom_range(0, 31)); o = 2'($urandom_range(0, 3));
      exp = ref_shift(d, int'(sh), o);
      launch(d, sh, o);
      wait_valid(lat, bc, to);
      n_cmp++; if (to || lat != $countones(sh)) begin
        n_err++; $display("FAIL rnd%0d_latency got=%0d exp=%0d timeout=%b", i, lat, $countones(sh), to);
      end
      n_cmp++; if (result !== exp) begin
        n_err++; $display("FAIL rnd%0d_result op=%0d d=%h sh=%0d got=%h exp=%h", i, o, d, sh, result, exp);
      end
      @(posedge clock); #1;
      n_cmp++; if (result_valid !== 1'b0 || result !== exp) begin
        n_err++; $display("FAIL rnd%0d_pulse valid=%b result=%h exp valid=0 result=%h", i, result_valid, result, exp);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int lat, bc, extra; bit to;
    launch(32'h0000_0001, 5'd3, 2'd0);
    n_cmp++; if (busy !== 1'b1 || ready !== 1'b0) begin
      n_err++; $display("FAIL ign_busy busy=%b ready=%b exp busy=1 ready=0", busy, ready);
    end
    start = 1'b1; data_in = 32'hFFFF_FFFF; shamt = 5'd8; op = 2'd1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_valid(lat, bc, to);
    n_cmp++; if (to || lat != 1) begin n_err++; $display("FAIL ign_latency got=%0d exp=1 timeout=%b", lat, to); end
    n_cmp++; if (result !== 32'h0000_0008) begin n_err++; $display("FAIL ign_result got=%h exp=00000008", result); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (result_valid) extra++;
    end
    n_cmp++; if (extra != 0) begin n_err++; $display("FAIL ign_second_valid got=%0d pulses exp=0", extra); end
    n_cmp++; if (result !== 32'h0000_0008) begin n_err++; $display("FAIL ign_hold got=%h exp=00000008", result); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [4:0] sh; int lat, bc; bit to;
    d = $urandom; sh = 5'($urandom_range(1, 31));
    launch(d, sh, 2'd3);
    wait_valid(lat, bc, to);
    n_cmp++; if (to || result !== ref_shift(d, int'(sh), 2'd3)) begin
      n_err++; $display("FAIL b2b_first got=%h exp=%h timeout=%b", result, ref_shift(d, int'(sh), 2'd3), to);
    end
    // Still in the DONE cycle: request the next operation right away.
    start = 1'b1; data_in = 32'hF000_0000; shamt = 5'd28; op = 2'd1;
    @(posedge clock); #1;
    start = 1'b0; data_in = $urandom;
    n_cmp++; if (busy !== 1'b1 || result_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_accept busy=%b valid=%b exp busy=1 valid=0", busy, result_valid);
    end
    wait_valid(lat, bc, to);
    n_cmp++; if (to || lat != 3) begin n_err++; $display("FAIL b2b_latency got=%0d exp=3 timeout=%b", lat, to); end
    n_cmp++; if (result !== 32'h0000_000F) begin n_err++; $display("FAIL b2b_result got=%h exp=0000000f", result); end
    // Zero-shift back-to-back keeps result_valid high two cycles running.
    start = 1'b1; data_in = 32'h1234_5678; shamt = 5'd0; op = 2'd2;
    @(posedge clock); #1;
    start = 1'b0;
    n_cmp++; if (result_valid !== 1'b1 || result !== 32'h1234_5678) begin
      n_err++; $display("FAIL b2b_zero valid=%b result=%h exp valid=1 result=12345678", result_valid, result);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    launch(32'h0000_0001, 5'd31, 2'd0);
    for (int i = 0; i < 2; i++) begin
      if (result_valid) pulses++;
      @(posedge clock); #1;
    end
    if (result_valid) pulses++;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_state ready=%b busy=%b exp ready=1 busy=0", ready, busy);
    end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL rstmid_result got=%h exp=0", result); end
    for (int i = 0; i < 10; i++) begin
      if (result_valid) pulses++;
      @(posedge clock); #1;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rstmid_valid got=%0d pulses exp=0", pulses); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
- Multi-cycle shift unit for the ALU shift path, used where a single-cycle 5-stage log shifter does not meet timing.
- Takes a start pulse with operand, shift amount and op, then applies one power-of-two shift step per cycle.
- Finishes with a one-cycle result_valid pulse and holds the result.
- Supports sll, srl, sra and rotate-left.

Parameters:
- WIDTH, 32, data width; must be 32 for the current core.
- SHAMT_W, 5, shift-amount width, equal to log2(WIDTH).

Ports:
- clock  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only when ready=1.
- data_in  input  32  operand.
- shamt  input  5  shift amount, 0..31.
- op  input  2  00 sll, 01 srl, 10 sra, 11 rol.
- ready  output  1  high in IDLE and DONE; new request can be accepted.
- busy  output  1  high in SHIFT.
- result  output  32  shifted value, held stable until the next accepted start.
- result_valid  output  1  one-cycle pulse when result is updated.

Behaviour:
- Reset (synchronous, active-high, priority over all else): state=IDLE, result=0, result_valid=0, ready=1, busy=0. Internal working registers (acc, rem, op_q) are cleared.
- Accept: start=1 and ready=1 at edge T latches acc<=data_in, rem<=shamt, op_q<=op.
  - rem!=0: next state SHIFT.
  - rem==0: next state DONE.
- SHIFT, each cycle:
  - k = index of the highest set bit of rem.
  - acc <= stage(acc, 2^k, op_q); rem bit k cleared.
  - When the updated rem==0, next state DONE.
- DONE, for one cycle:
  - result <= acc at entry to DONE, so result is visible in the DONE cycle.
  - result_valid=1.
  - Next state IDLE, or SHIFT/DONE when start=1 in the same cycle (back-to-back accept allowed).
- Latency: start sampled at edge T -> result_valid high in cycle T+1+popcount(shamt).
  - shamt=0: 1 cycle.
  - shamt=31: 6 cycles (maximum).
- Stage arithmetic, step s in {1,2,4,8,16}:
  - sll: zero fill from the LSB.
  - srl: zero fill from the MSB.
  - sra: fill with the operand bit 31 captured at accept. Sign is preserved across steps.
  - rol: bits shifted out of the MSB re-enter at the LSB.
- start while busy=1: ignored. No queuing and no error flag. Latched operands are unaffected.
- Input changes after accept: data_in/shamt/op changes while busy have no effect.
- Reset mid-SHIFT: aborts the operation. No result_valid is produced, and result reads 0 on the following cycle.
- ready and busy are decoded from state only; no combinational path from start.
- result_valid is registered.

Decomposition:
- Shared package shifter_pkg:
  - op encodings OP_SLL, OP_SRL, OP_SRA, OP_ROL.
  - State enum IDLE/SHIFT/DONE.
  - WIDTH/SHAMT_W constants.
- Sub-module shift_stage: combinational, inputs (val[31:0], step index k[2:0], op[1:0]), output val[31:0]. Implements one power-of-two step for all four ops.
- The FSM, the rem priority-select and the registers live in iterative_shifter.

Test Plan:
- op=sll, data_in=0x0000_0001, shamt=31, start at T -> busy for 5 cycles; result_valid at T+6; result=0x8000_0000.
- op=sra, data_in=0x8000_0000, shamt=4 -> result_valid at T+2, result=0xF800_0000. Same input with op=srl -> 0x0800_0000.
- op=rol, data_in=0x8000_0001, shamt=1 -> result=0x0000_0003. op=sll, data_in=0xDEAD_BEEF, shamt=0 -> result=0xDEAD_BEEF, valid at T+1.
- Accept sll 0x1 by 3, then pulse start with 0xFFFF_FFFF/shamt=8 while busy -> ignored; result=0x0000_0008 and no second valid.
- Back-to-back: start asserted during the DONE cycle with srl 0xF000_0000 by 28 -> accepted; next result=0x0000_000F with valid 4 cycles later.
- Reset asserted mid-SHIFT (sll 0x1 by 31, reset at T+3) -> next cycle state IDLE, result=0, ready=1; result_valid never pulses.
